// File: rtl/sb_mtrx_regs.sv
// Sideband register bank: scratch/ID/status registers, auto-incrementing pixel
// write port into the LED matrix frame buffer, and display buffer-swap tracking.
module sb_mtrx_regs #(
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned PIX_W       = 12,
  parameter int unsigned FB_AW       = 14,
  parameter int unsigned FB_DEPTH    = 16384,
  parameter logic [15:0] ID_WORD     = 16'hCAFE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sb_wr,
  input  logic             sb_rd,
  input  logic [15:0]      sb_addr,
  input  logic [15:0]      sb_wr_data,
  output logic [15:0]      sb_rd_data,
  output logic             rd_valid,
  output logic             pix_wr,
  output logic [FB_AW-1:0] pix_addr,
  output logic [PIX_W-1:0] pix_data,
  output logic             buf_select,
  input  logic             buf_current,
  output logic             swap_done
);

  localparam logic [15:0]    A_MADDR  = 16'd8;
  localparam logic [15:0]    A_MDATA  = 16'd9;
  localparam logic [15:0]    A_CTRL   = 16'd10;
  localparam logic [15:0]    A_STATUS = 16'd11;
  localparam logic [15:0]    A_ID     = 16'd12;
  localparam logic [FB_AW:0] DEPTH_C  = (FB_AW+1)'(FB_DEPTH);

  logic [15:0]      scratch_q [NUM_SCRATCH];
  logic [15:0]      scratch_d [NUM_SCRATCH];
  logic [FB_AW-1:0] maddr_q, maddr_d;
  logic [3:0]       stride_q, stride_d;
  logic             sel_q, sel_d;
  logic             pending_q, pending_d;
  logic             swap_done_q, swap_done_d;
  logic             pix_wr_q, pix_wr_d;
  logic [FB_AW-1:0] pix_addr_q, pix_addr_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      rd_data_q, rd_data_d;

  logic             wr_maddr, wr_mdata, wr_ctrl;
  logic             swap_req, swap_hit;
  logic [3:0]       inc;
  logic [FB_AW:0]   ptr_sum, ptr_wrap;
  logic [31:0]      wr_ext;
  logic [15:0]      rd_mux;

  always_comb begin
    wr_maddr = sb_wr && (sb_addr == A_MADDR);
    wr_mdata = sb_wr && (sb_addr == A_MDATA);
    wr_ctrl  = sb_wr && (sb_addr == A_CTRL);
    wr_ext   = 32'(sb_wr_data);

    inc      = (stride_q == 4'd0) ? 4'd1 : stride_q;
    ptr_sum  = {1'b0, maddr_q} + (FB_AW+1)'(inc);
    ptr_wrap = ptr_sum - DEPTH_C;

    maddr_d = maddr_q;
    if (wr_maddr) begin
      // Out-of-range loads snap to 0 rather than folding modulo the depth.
      maddr_d = (wr_ext < 32'(FB_DEPTH)) ? wr_ext[FB_AW-1:0] : '0;
    end else if (wr_mdata) begin
      maddr_d = (ptr_sum >= DEPTH_C) ? ptr_wrap[FB_AW-1:0] : ptr_sum[FB_AW-1:0];
    end

    pix_wr_d   = wr_mdata;
    pix_addr_d = wr_mdata ? maddr_q : pix_addr_q;
    pix_data_d = wr_mdata ? sb_wr_data[PIX_W-1:0] : pix_data_q;

    stride_d = wr_ctrl ? sb_wr_data[11:8] : stride_q;
    sel_d    = wr_ctrl ? sb_wr_data[0] : sel_q;

    // A new select request supersedes a completion seen in the same cycle.
    swap_req    = wr_ctrl && (sb_wr_data[0] != sel_q);
    swap_hit    = pending_q && (buf_current == sel_q);
    swap_done_d = swap_hit && !swap_req;
    pending_d   = swap_req ? 1'b1 : (swap_hit ? 1'b0 : pending_q);

    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = (sb_wr && (sb_addr == 16'(i))) ? sb_wr_data : scratch_q[i];
    end

    rd_mux = 16'hFFFF;
    case (sb_addr)
      A_MADDR:  rd_mux = 16'(maddr_q);
      A_CTRL:   rd_mux = {4'h0, stride_q, 7'h00, sel_q};
      A_STATUS: rd_mux = {14'h0000, buf_current, pending_q};
      A_ID:     rd_mux = ID_WORD;
      default:  rd_mux = 16'hFFFF;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (sb_addr == 16'(i)) rd_mux = scratch_q[i];
    end

    rd_valid_d = sb_rd;
    rd_data_d  = sb_rd ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      maddr_q     <= '0;
      stride_q    <= '0;
      sel_q       <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      pix_wr_q    <= 1'b0;
      pix_addr_q  <= '0;
      pix_data_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 16'hFFFF;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
      maddr_q     <= maddr_d;
      stride_q    <= stride_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      pix_wr_q    <= pix_wr_d;
      pix_addr_q  <= pix_addr_d;
      pix_data_q  <= pix_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign sb_rd_data = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign pix_wr     = pix_wr_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign buf_select = sel_q;
  assign swap_done  = swap_done_q;

endmodule

// File: tb/tb_sb_mtrx_regs.sv
// Directed bench for sb_mtrx_regs: reads and pixel writes are checked against
// queues of expected values filled when the stimulus is driven.
module tb_sb_mtrx_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sb_wr = 1'b0;
  logic        sb_rd = 1'b0;
  logic [15:0] sb_addr = '0;
  logic [15:0] sb_wr_data = '0;
  logic [15:0] sb_rd_data;
  logic        rd_valid;
  logic        pix_wr;
  logic [13:0] pix_addr;
  logic [11:0] pix_data;
  logic        buf_select;
  logic        buf_current = 1'b0;
  logic        swap_done;

  int checks = 0;
  int errors = 0;
  int sd_cnt = 0;

  logic [15:0] rd_q [$];
  logic [25:0] pix_q [$];
  logic [13:0] m_ptr = '0;
  logic [3:0]  m_stride = '0;

  sb_mtrx_regs dut (
    .clk(clk), .rst(rst), .sb_wr(sb_wr), .sb_rd(sb_rd), .sb_addr(sb_addr),
    .sb_wr_data(sb_wr_data), .sb_rd_data(sb_rd_data), .rd_valid(rd_valid),
    .pix_wr(pix_wr), .pix_addr(pix_addr), .pix_data(pix_data),
    .buf_select(buf_select), .buf_current(buf_current), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: every rd_valid / pix_wr pops one expected entry.
  always @(negedge clk) begin
    if (swap_done) sd_cnt++;
    if (!rst && rd_valid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
      else chk("rd_data", 32'(sb_rd_data), 32'(rd_q.pop_front()));
    end
    if (!rst && pix_wr) begin
      if (pix_q.size() == 0) chk("pix_unexpected", 32'(pix_wr), 32'd0);
      else chk("pix_addr_data", 32'({pix_addr, pix_data}), 32'(pix_q.pop_front()));
    end
  end

  task automatic cyc(input logic wr, input logic rd, input logic [15:0] addr,
                     input logic [15:0] data);
    @(negedge clk);
    sb_wr = wr; sb_rd = rd; sb_addr = addr; sb_wr_data = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sb_wr = 1'b0; sb_rd = 1'b0;
    end
  endtask

  task automatic model_wr(input logic [15:0] addr, input logic [15:0] data);
    int nxt;
    if (addr == 16'd8) m_ptr = (data < 16'd16384) ? data[13:0] : 14'd0;
    if (addr == 16'd10) m_stride = data[11:8];
    if (addr == 16'd9) begin
      pix_q.push_back({m_ptr, data[11:0]});
      nxt = int'(m_ptr) + ((m_stride == 4'd0) ? 1 : int'(m_stride));
      if (nxt >= 16384) nxt = nxt - 16384;
      m_ptr = 14'(nxt);
    end
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [15:0] data);
    model_wr(addr, data);
    cyc(1'b1, 1'b0, addr, data);
  endtask

  task automatic rd_reg(input logic [15:0] addr, input logic [15:0] exp);
    rd_q.push_back(exp);
    cyc(1'b0, 1'b1, addr, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values and constant/status readback
    repeat (3) @(negedge clk);
    chk("rst_rd_data", 32'(sb_rd_data), 32'h0000FFFF);
    chk("rst_pix_wr", 32'(pix_wr), 32'd0);
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_buf_select", 32'(buf_select), 32'd0);
    rst = 1'b0;
    rd_reg(16'd8, 16'h0000);
    rd_reg(16'd10, 16'h0000);
    rd_reg(16'd11, 16'h0000);
    rd_reg(16'd12, 16'hCAFE);
    idle(2);

    // 2: sequential pixel writes, back to back
    wr_reg(16'd8, 16'h0010);
    wr_reg(16'd9, 16'h0ABC);
    wr_reg(16'd9, 16'h0123);
    rd_reg(16'd8, 16'h0012);
    wr_reg(16'd8, 16'h4000);
    rd_reg(16'd8, 16'h0000);
    idle(2);

    // 3: stride 3 wrapping at the top of the frame buffer
    wr_reg(16'd8, 16'h3FFE);
    wr_reg(16'd10, 16'h0300);
    wr_reg(16'd9, 16'h0111);
    wr_reg(16'd9, 16'h0222);
    wr_reg(16'd9, 16'h0333);
    rd_reg(16'd8, 16'h0007);
    rd_reg(16'd10, 16'h0300);
    idle(2);

    // 4: buffer swap request and completion
    wr_reg(16'd10, 16'h0301);
    rd_reg(16'd11, 16'h0001);
    idle(20);
    chk("swap_done_early", 32'(sd_cnt), 32'd0);
    chk("buf_select", 32'(buf_select), 32'd1);
    buf_current = 1'b1;
    idle(3);
    chk("swap_done_pulses", 32'(sd_cnt), 32'd1);
    chk("swap_done_low", 32'(swap_done), 32'd0);
    rd_reg(16'd11, 16'h0002);
    idle(2);

    // 5: simultaneous read/write returns the old value; unmapped offsets
    model_wr(16'd0, 16'h5A5A);
    rd_q.push_back(16'h0000);
    cyc(1'b1, 1'b1, 16'd0, 16'h5A5A);
    rd_reg(16'd0, 16'h5A5A);
    rd_reg(16'd7, 16'hFFFF);
    rd_reg(16'd9, 16'hFFFF);
    rd_reg(16'd13, 16'hFFFF);
    idle(2);

    // 6: reset asserted in the middle of a pixel burst
    wr_reg(16'd8, 16'h0020);
    wr_reg(16'd9, 16'h0444);
    idle(1);
    @(posedge clk); #2;
    rst = 1'b1;
    sb_wr = 1'b1; sb_addr = 16'd9; sb_wr_data = 16'h0555;
    @(negedge clk);
    chk("rst_burst_pix_wr_a", 32'(pix_wr), 32'd0);
    @(negedge clk);
    chk("rst_burst_pix_wr_b", 32'(pix_wr), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    sb_wr = 1'b0;
    buf_current = 1'b0;
    m_ptr = '0; m_stride = '0;
    rd_reg(16'd8, 16'h0000);
    rd_reg(16'd11, 16'h0000);
    idle(3);
    chk("buf_select_after_rst", 32'(buf_select), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
